qdr_rst_seq: RTL and testbench
==============================

# qdr_rst_seq

Reset sequencer between the clock wizard and the QDRII memory controller. It watches the MMCM `locked` output and the controller's `cal_done`, holds the controller in reset until the clocks are stable, and then releases user logic only after calibration completes. With the timeout option compiled in, it re-issues memory reset when calibration stalls and gives up after a bounded number of retries. Every output is a registered level in the `sys_clk` domain.

## Interface
- `C_LOCK_CYCLES`, 1024: cycles `locked` must stay high before memory reset starts.
- `C_RST_CYCLES`, 256: number of cycles `mem_rst` is held in HOLD_RST.
- `C_CAL_TIMEOUT`, 1048576: cycles allowed in WAIT_CAL before a retry.
- `C_MAX_RETRY`, 3: number of retries before FAIL; range 0..15.
- `sys_clk` input 1: single clock for the block; the controller's sys_clk.
- `sys_rst` input 1: asynchronous, active-high reset.
- `locked` input 1: MMCM lock, asynchronous to `sys_clk`.
- `cal_done` input 1: controller calibration complete, asynchronous.
- `mem_rst` output 1: active-high reset to the memory controller.
- `user_rst` output 1: active-high reset to user logic.
- `state` output 3: current state encoding, for debug.
- `retry_cnt` output 4: retries consumed.
- `fail` output 1: sticky calibration failure.

## Operation
- `locked` and `cal_done` each pass through a 2-flop synchronizer, giving `locked_s` and `cal_done_s`. These are the only forms used internally.
- There is one shared down-counter. Its width is clog2 of the largest of the three cycle parameters.
- States and encodings: WAIT_LOCK=0, LOCK_STABLE=1, HOLD_RST=2, WAIT_CAL=3, RUN=4, FAIL=5.
- WAIT_LOCK: when `locked_s`=1, go to LOCK_STABLE and load the counter.
- LOCK_STABLE: if `locked_s`=0, return to WAIT_LOCK. After C_LOCK_CYCLES cycles with `locked_s` continuously high, go to HOLD_RST.
- HOLD_RST: after C_RST_CYCLES cycles, go to WAIT_CAL.
- WAIT_CAL: if `cal_done_s`=1, go to RUN. On timeout:
  - if `retry_cnt`==C_MAX_RETRY, go to FAIL;
  - otherwise increment `retry_cnt` and go to HOLD_RST.
- RUN: stays here while `locked_s`=1.
- FAIL: terminal. Only `sys_rst` exits it; lock changes are ignored.
- Lock loss: in LOCK_STABLE, HOLD_RST, WAIT_CAL or RUN, `locked_s`=0 forces WAIT_LOCK and clears `retry_cnt`.
- Priority, highest first: `sys_rst`, then lock loss, then `cal_done_s`, then timeout. `cal_done_s` and timeout in the same cycle resolve to RUN.
- `mem_rst`=1 in WAIT_LOCK, LOCK_STABLE, HOLD_RST and FAIL; 0 in WAIT_CAL and RUN.
- `user_rst`=0 only in RUN.
- `fail`=1 only in FAIL.
- A `cal_done_s` deassertion while in RUN is ignored.

## Timing
- Reset values: `mem_rst`=1, `user_rst`=1, `state`=0, `retry_cnt`=0, `fail`=0. The synchronizer flops reset to 0.
- Outputs are decoded from registered state and change on the edge where the state changes.
- Synchronizer latency is 2 cycles.
- `locked` rising to `mem_rst` falling: 2 + 1 + C_LOCK_CYCLES + C_RST_CYCLES cycles.
- `cal_done` rising to `user_rst` falling: 3 cycles.
- `locked` falling to `mem_rst`/`user_rst` rising: 3 cycles.
- Timeout fires on the C_CAL_TIMEOUT-th cycle spent in WAIT_CAL. `mem_rst` reasserts on the next edge.
- An asynchronous `sys_rst` mid-sequence returns every output to its reset value immediately.

## Configuration
- Macro: `QDR_RST_SEQ_CAL_TIMEOUT_EN`.
- Defined: timeout and retry behave as described above.
- Undefined:
  - WAIT_CAL waits indefinitely for `cal_done_s`;
  - FAIL is unreachable;
  - `retry_cnt` and `fail` are tied to 0;
  - the C_CAL_TIMEOUT and C_MAX_RETRY parameters are kept but unused.

## Structure
- Package `qdr_rst_pkg` holds:
  - the state encoding constants (3 bits);
  - a `clog2` counter-width function;
  - the retry counter width constant (4).
- Sub-module `qdr_sync2` is the 2-flop synchronizer: async active-high reset, reset value 0. It is instantiated twice, once for `locked` and once for `cal_done`.

## Test plan
All scenarios use C_LOCK_CYCLES=4, C_RST_CYCLES=3, C_CAL_TIMEOUT=8, C_MAX_RETRY=1.
- Nominal: raise `locked` at cycle 0 → `mem_rst` falls at cycle 10. Raise `cal_done` 5 cycles later → `user_rst` falls 3 cycles after that, and `state`=4.
- Lock glitch: drop `locked` for 1 cycle, 2 cycles into LOCK_STABLE → state returns to 0 and the full 10-cycle sequence restarts from the re-rise.
- Retry: hold `cal_done`=0 → after 8 cycles in WAIT_CAL, `retry_cnt`=1 and `mem_rst`=1 for 3 cycles. Raise `cal_done` in the second WAIT_CAL → reach RUN.
- Fail: never raise `cal_done` → after the second timeout, `state`=5, `fail`=1, `mem_rst`=1, `user_rst`=1. Toggling `locked` changes nothing; pulsing `sys_rst` clears all outputs to reset values.
- Lock loss in RUN: drop `locked` → `mem_rst` and `user_rst` are 1 three cycles later, and `retry_cnt`=0.
- Simultaneous: `cal_done_s` rises on the 8th WAIT_CAL cycle → RUN entered and `retry_cnt` unchanged. Repeat with the macro undefined → no timeout after 100 cycles, and `fail` stays 0.

Source files
------------

// File: rtl/qdr_rst_pkg.sv
// Shared types and helpers for the QDRII reset sequencer: state encoding,
// retry counter width and the counter-width function.
package qdr_rst_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    S_WAIT_LOCK   = 3'd0,
    S_LOCK_STABLE = 3'd1,
    S_HOLD_RST    = 3'd2,
    S_WAIT_CAL    = 3'd3,
    S_RUN         = 3'd4,
    S_FAIL        = 3'd5
  } state_e;

  // Bits needed to hold value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qdr_rst_seq_if.sv
// Signal bundle between the reset sequencer and its environment
// (clock wizard lock, controller calibration and the reset outputs).
interface qdr_rst_seq_if;
  import qdr_rst_pkg::*;

  logic               locked;
  logic               cal_done;
  logic               mem_rst;
  logic               user_rst;
  logic [2:0]         state;
  logic [RETRY_W-1:0] retry_cnt;
  logic               fail;

  modport master (
    output locked, cal_done,
    input  mem_rst, user_rst, state, retry_cnt, fail
  );

  modport slave (
    input  locked, cal_done,
    output mem_rst, user_rst, state, retry_cnt, fail
  );

endinterface

// File: rtl/qdr_sync2.sv
// Two-flop synchronizer for a single asynchronous level, async active-high
// reset to 0.
module qdr_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability chain into the i_clk domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/qdr_rst_seq.sv
// Reset sequencer between the MMCM and the QDRII controller.
// Optional calibration timeout/retry: define QDR_RST_SEQ_CAL_TIMEOUT_EN.
module qdr_rst_seq
  import qdr_rst_pkg::*;
#(
  parameter int C_LOCK_CYCLES = 1024,
  parameter int C_RST_CYCLES  = 256,
  parameter int C_CAL_TIMEOUT = 1048576,
  parameter int C_MAX_RETRY   = 3
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  qdr_rst_seq_if.slave  bus
);

  localparam int CNT_W = clog2(max3(C_LOCK_CYCLES, C_RST_CYCLES, C_CAL_TIMEOUT));
  localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(C_LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(C_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CAL  = CNT_W'(C_CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic w_locked_s;
  logic w_cal_done_s;

  qdr_sync2 u_sync_locked (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_d   (bus.locked),
    .o_q   (w_locked_s)
  );

  qdr_sync2 u_sync_cal_done (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_d   (bus.cal_done),
    .o_q   (w_cal_done_s)
  );

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_rst;
  logic             r_user_rst;
`ifdef QDR_RST_SEQ_CAL_TIMEOUT_EN
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(C_MAX_RETRY);
  logic [RETRY_W-1:0] r_retry;
  logic               r_fail;
`endif

  // Sequencer FSM; outputs are registered alongside the state transition.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_WAIT_LOCK;
      r_cnt      <= CNT_ZERO;
      r_mem_rst  <= 1'b1;
      r_user_rst <= 1'b1;
`ifdef QDR_RST_SEQ_CAL_TIMEOUT_EN
      r_retry    <= {RETRY_W{1'b0}};
      r_fail     <= 1'b0;
`endif
    end else if (!w_locked_s && (r_state != S_WAIT_LOCK) && (r_state != S_FAIL)) begin
      r_state    <= S_WAIT_LOCK;
      r_mem_rst  <= 1'b1;
      r_user_rst <= 1'b1;
`ifdef QDR_RST_SEQ_CAL_TIMEOUT_EN
      r_retry    <= {RETRY_W{1'b0}};
`endif
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= S_LOCK_STABLE;
            r_cnt   <= CNT_LOCK;
          end
        end
        S_LOCK_STABLE: begin
          if (r_cnt == CNT_ZERO) begin
            r_state <= S_HOLD_RST;
            r_cnt   <= CNT_RST;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_HOLD_RST: begin
          if (r_cnt == CNT_ZERO) begin
            r_state   <= S_WAIT_CAL;
            r_mem_rst <= 1'b0;
            r_cnt     <= CNT_CAL;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_WAIT_CAL: begin
          // Calibration done outranks a timeout landing on the same cycle.
          if (w_cal_done_s) begin
            r_state    <= S_RUN;
            r_user_rst <= 1'b0;
`ifdef QDR_RST_SEQ_CAL_TIMEOUT_EN
          end else if (r_cnt == CNT_ZERO) begin
            r_mem_rst <= 1'b1;
            if (r_retry == RETRY_LIM) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_state <= S_HOLD_RST;
              r_retry <= r_retry + {{(RETRY_W-1){1'b0}}, 1'b1};
              r_cnt   <= CNT_RST;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
`endif
          end
        end
        S_RUN:  r_state <= S_RUN;
        S_FAIL: r_state <= S_FAIL;
        default: begin
          r_state    <= S_WAIT_LOCK;
          r_mem_rst  <= 1'b1;
          r_user_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_rst  = r_mem_rst;
  assign bus.user_rst = r_user_rst;
  assign bus.state    = r_state;
`ifdef QDR_RST_SEQ_CAL_TIMEOUT_EN
  assign bus.retry_cnt = r_retry;
  assign bus.fail      = r_fail;
`else
  assign bus.retry_cnt = {RETRY_W{1'b0}};
  assign bus.fail      = 1'b0;
`endif

endmodule

// File: tb/tb_qdr_rst_seq.sv
// Self-checking bench for qdr_rst_seq: directed timing scenarios plus a
// randomized run against an elapsed-cycle phase model.
module tb_qdr_rst_seq;

  localparam int LOCK_N = 4;
  localparam int RST_N  = 3;
  localparam int CAL_N  = 8;
  localparam int MAXR   = 1;
`ifdef QDR_RST_SEQ_CAL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [3:0] RC1 = TO_EN ? 4'd1 : 4'd0;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  qdr_rst_seq_if bus ();

  qdr_rst_seq #(
    .C_LOCK_CYCLES (LOCK_N),
    .C_RST_CYCLES  (RST_N),
    .C_CAL_TIMEOUT (CAL_N),
    .C_MAX_RETRY   (MAXR)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase number, cycles elapsed in the phase, retries used,
  // and the two-stage delay each asynchronous input sees.
  int m_ph, m_n, m_retry;
  bit m_lk_m, m_lk_s, m_cd_m, m_cd_s;

  task automatic model_reset();
    m_ph = 0; m_n = 0; m_retry = 0;
    m_lk_m = 1'b0; m_lk_s = 1'b0; m_cd_m = 1'b0; m_cd_s = 1'b0;
  endtask

  task automatic model_step();
    bit lk, cd;
    if (rst) begin
      model_reset();
    end else begin
      lk = m_lk_s; cd = m_cd_s;
      m_lk_s = m_lk_m; m_lk_m = bus.locked;
      m_cd_s = m_cd_m; m_cd_m = bus.cal_done;
      m_n = m_n + 1;
      if (m_ph == 0) begin
        if (lk) begin m_ph = 1; m_n = 0; end
      end else if (m_ph == 5) begin
        m_ph = 5;
      end else if (!lk) begin
        m_ph = 0; m_n = 0; m_retry = 0;
      end else if (m_ph == 1 && m_n == LOCK_N) begin
        m_ph = 2; m_n = 0;
      end else if (m_ph == 2 && m_n == RST_N) begin
        m_ph = 3; m_n = 0;
      end else if (m_ph == 3 && cd) begin
        m_ph = 4;
      end else if (m_ph == 3 && TO_EN && m_n == CAL_N) begin
        if (m_retry == MAXR) m_ph = 5;
        else begin m_retry = m_retry + 1; m_ph = 2; end
        m_n = 0;
      end
    end
  endtask

  function automatic logic [9:0] pack(input logic [2:0] st, input logic m, input logic u,
                                      input logic [3:0] r, input logic f);
    return {st, m, u, r, f};
  endfunction

  function automatic logic [9:0] exp_vec();
    return pack(3'(m_ph), (m_ph <= 2 || m_ph == 5), (m_ph != 4), 4'(m_retry), (m_ph == 5));
  endfunction

  function automatic logic [9:0] obs_vec();
    return {bus.state, bus.mem_rst, bus.user_rst, bus.retry_cnt, bus.fail};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.locked = 1'b0; bus.cal_done = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    e = pack(3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    #1;
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL reset_initial: got %b want %b", obs_vec(), e); end
    repeat (3) tick();
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL reset_held: got %b want %b", obs_vec(), e); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [9:0] e;
    do_reset();
    bus.locked = 1'b1;
    repeat (9) tick();
    e = pack(3'd2, 1'b1, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL nom_cycle9: got %b want %b", obs_vec(), e); end
    tick();
    e = pack(3'd3, 1'b0, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL nom_memrst_fall: got %b want %b", obs_vec(), e); end
    repeat (5) tick();
    bus.cal_done = 1'b1;
    repeat (2) tick();
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL nom_cal_sync: got %b want %b", obs_vec(), e); end
    tick();
    e = pack(3'd4, 1'b0, 1'b0, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL nom_run_simul: got %b want %b", obs_vec(), e); end
  endtask

  task automatic test_lock_glitch();
    logic [9:0] e;
    do_reset();
    bus.locked = 1'b1;
    repeat (4) tick();
    e = pack(3'd1, 1'b1, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL glitch_stable: got %b want %b", obs_vec(), e); end
    bus.locked = 1'b0;
    tick();
    bus.locked = 1'b1;
    repeat (2) tick();
    e = pack(3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL glitch_back: got %b want %b", obs_vec(), e); end
    repeat (7) tick();
    e = pack(3'd2, 1'b1, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL glitch_hold9: got %b want %b", obs_vec(), e); end
    tick();
    e = pack(3'd3, 1'b0, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL glitch_rel10: got %b want %b", obs_vec(), e); end
  endtask

  task automatic test_retry();
    logic [9:0] e;
    do_reset();
    bus.locked = 1'b1;
    repeat (17) tick();
    e = pack(3'd3, 1'b0, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL retry_pre: got %b want %b", obs_vec(), e); end
    tick();
`ifdef QDR_RST_SEQ_CAL_TIMEOUT_EN
    e = pack(3'd2, 1'b1, 1'b1, 4'd1, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL retry_fire: got %b want %b", obs_vec(), e); end
    repeat (2) tick();
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL retry_hold: got %b want %b", obs_vec(), e); end
    tick();
    e = pack(3'd3, 1'b0, 1'b1, 4'd1, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL retry_rel: got %b want %b", obs_vec(), e); end
`else
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL no_timeout8: got %b want %b", obs_vec(), e); end
    repeat (100) tick();
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL no_timeout100: got %b want %b", obs_vec(), e); end
`endif
    bus.cal_done = 1'b1;
    repeat (3) tick();
    e = pack(3'd4, 1'b0, 1'b0, RC1, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL retry_run: got %b want %b", obs_vec(), e); end
  endtask

  task automatic test_fail();
    logic [9:0] e;
    do_reset();
    bus.locked = 1'b1;
    repeat (28) tick();
    e = pack(3'd3, 1'b0, 1'b1, RC1, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL fail_pre: got %b want %b", obs_vec(), e); end
    tick();
`ifdef QDR_RST_SEQ_CAL_TIMEOUT_EN
    e = pack(3'd5, 1'b1, 1'b1, 4'd1, 1'b1);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL fail_enter: got %b want %b", obs_vec(), e); end
    bus.locked = 1'b0;
    repeat (5) tick();
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL fail_lock_lo: got %b want %b", obs_vec(), e); end
    bus.locked = 1'b1;
    repeat (5) tick();
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL fail_lock_hi: got %b want %b", obs_vec(), e); end
`else
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL nofail_29: got %b want %b", obs_vec(), e); end
`endif
    rst = 1'b1;
    #1;
    e = pack(3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL async_rst: got %b want %b", obs_vec(), e); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_lock_loss_run();
    logic [9:0] e;
    do_reset();
    bus.locked = 1'b1;
    repeat (18) tick();
    bus.cal_done = 1'b1;
    repeat (5) tick();
    e = pack(3'd4, 1'b0, 1'b0, RC1, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL loss_in_run: got %b want %b", obs_vec(), e); end
    bus.cal_done = 1'b0;
    repeat (4) tick();
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL run_cal_drop: got %b want %b", obs_vec(), e); end
    bus.locked = 1'b0;
    repeat (2) tick();
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL loss_pre: got %b want %b", obs_vec(), e); end
    tick();
    e = pack(3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    n_vec++; if (obs_vec() !== e) begin n_err++; $display("FAIL loss_rst: got %b want %b", obs_vec(), e); end
  endtask

  task automatic test_random();
    int seg;
    do_reset();
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        bus.locked = ~bus.locked;
        seg = bus.locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 4));
      end
      seg = seg - 1;
      if ($urandom_range(0, 19) == 0) bus.cal_done = ~bus.cal_done;
      rst = ($urandom_range(0, 499) == 0);
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.locked = 1'b0;
    bus.cal_done = 1'b0;
    model_reset();
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_retry();
    test_fail();
    test_lock_loss_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
